hv_temporal_encoder: RTL and testbench
======================================

Name: hv_temporal_encoder

Overview:
- Temporal (N-gram) encoder of the HDC sensor-fusion pipeline, placed after the spatial/fusion encoder and before the associative memory.
- For each accepted fused hypervector it emits one temporal hypervector: the XOR of the current input with circularly permuted copies of the previous N-1 inputs.
- Uses valid/ready handshakes on both sides, with one output per input (1:1, including the first N-1 inputs).

Parameters:
- HV_DIMENSION, 2000: hypervector width in bits (codebase const.vh `HV_DIMENSION).
- NGRAM, 3: N-gram length. Legal range is 1..8. NGRAM=1 means pass-through.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-low reset.
- hvin_valid  in  1  Input hypervector valid.
- hvin_ready  out  1  Encoder can accept an input this cycle.
- hvin  in  HV_DIMENSION  Fused spatial hypervector.
- hvout_valid  out  1  Output hypervector valid.
- hvout_ready  in  1  Downstream accepts the output.
- hvout  out  HV_DIMENSION  Temporal-encoded hypervector.

Behaviour:
- Reset (rst==0 at posedge): hvout_valid=0, hvout=0, and all history registers h[1..NGRAM-1] cleared to 0. hvin_ready follows its combinational equation.
- Permutation rho(x) = rotate left by one bit: {x[D-2:0], x[D-1]}. rho^k means k rotations.
- Encoding: out = hvin XOR rho(h[1]) XOR rho^2(h[2]) XOR ... XOR rho^(NGRAM-1)(h[NGRAM-1]).
  - h[1] is the most recently accepted input, h[2] the one before it, and so on.
  - Pure bitwise logic; no arithmetic.
- Accept: input is accepted when hvin_valid && hvin_ready at a posedge.
- hvin_ready = !hvout_valid || hvout_ready (combinational; single output register; no skid buffer).
- On accept:
  - hvout <= encoded value and hvout_valid <= 1.
  - History shifts: h[k] <= h[k-1], and h[1] <= hvin.
- Latency: output is valid the cycle after accept. Full throughput is 1 per cycle while hvout_ready is held high.
- On hvout_valid && hvout_ready without a new accept: hvout_valid <= 0. hvout holds its last value.
- Simultaneous output handshake and input accept: output register is reloaded with the new value and hvout_valid stays 1.
- Backpressure: while hvout_valid && !hvout_ready:
  - hvout and hvout_valid are held stable.
  - hvin_ready=0 and history does not change.
- Start-up: the first NGRAM-1 outputs use the zeroed history. Output 0 equals hvin[0]; output 1 equals hvin[1] ^ rho(hvin[0]).
- hvin_valid without ready causes no state change. hvin may change freely while it is not being accepted.
- Reset mid-operation: any pending output is dropped and the history is cleared. The next input is treated as stream start.

Optional Feature:
- Macro TEMPORAL_ENCODER_FLUSH_EN.
- Defined: adds input port flush (1 bit, active-high, synchronous).
  - flush=1 clears h[1..NGRAM-1] to 0 at the posedge.
  - If an accept occurs in the same cycle, the encoding uses the old history, and afterwards h[1]=hvin with all other history zero.
  - flush does not affect hvout/hvout_valid.
- Undefined: no port; history is cleared only by rst.

Decomposition:
- Shared package hdc_pkg holds HV_DIMENSION, a typedef hv_t (logic [HV_DIMENSION-1:0]) and the function rotl1(hv_t).
- One sub-module is natural: hv_permute (combinational rotate-left-by-K, parameter K), instantiated NGRAM-1 times.

Test Plan:
- Reset then first inputs, D=8, NGRAM=3:
  - in0=8'b0000_0001 -> out0=8'b0000_0001.
  - in1=8'b1000_0000 -> out1=1000_0000 ^ rho(0000_0001)=1000_0010.
  - in2=8'b0000_0000 -> out2=rho(1000_0000) ^ rho^2(0000_0001) = 0000_0001 ^ 0000_0100 = 0000_0101.
- Backpressure: hvout_ready=0 for 10 cycles with hvin_valid=1 -> hvin_ready=0, and hvout is stable and unchanged. Releasing ready yields the next output with no data lost.
- Streaming with hvout_ready=1 and hvin_valid=1 each cycle -> one output per cycle, 1-cycle latency, matching the golden model.
- Randomized valid/ready gaps (0-15 cycles) over the 380-vector D=2000 dataset -> all 380 outputs match the golden file, in order.
- Reset asserted mid-stream (after 5 inputs) -> hvout_valid=0. The next input's output equals that input unchanged.
- With TEMPORAL_ENCODER_FLUSH_EN: flush pulse, then input X -> output equals X.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared HDC definitions: hypervector width, hypervector type and the
// single-step permutation used throughout the pipeline.
package hdc_pkg;

  localparam int HV_DIMENSION = 2000;
  localparam int NGRAM_MAX    = 8;

  typedef logic [HV_DIMENSION-1:0] hv_t;

  // rho(x): rotate left by one bit position
  function automatic hv_t rotl1(input hv_t x);
    return {x[HV_DIMENSION-2:0], x[HV_DIMENSION-1]};
  endfunction

endpackage

// File: rtl/hv_permute.sv
// Combinational rho^K permutation: rotate a W-bit hypervector left by K bits.
// Pure wiring, no logic cells.
module hv_permute
  import hdc_pkg::*;
#(
  parameter int W = HV_DIMENSION,
  parameter int K = 1
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  localparam int KM = K % W;

  if (KM == 0) begin : g_pass
    assign y_o = x_i;
  end else begin : g_rot
    assign y_o = {x_i[W-1-KM:0], x_i[W-1:W-KM]};
  end

endmodule

// File: rtl/hv_temporal_encoder.sv
// N-gram temporal encoder: out = hvin ^ rho(h1) ^ ... ^ rho^(N-1)(h[N-1]), one
// output per accepted input. Optional history flush port via TEMPORAL_ENCODER_FLUSH_EN.
module hv_temporal_encoder #(
  parameter int HV_DIMENSION = hdc_pkg::HV_DIMENSION,
  parameter int NGRAM        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef TEMPORAL_ENCODER_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout
);

  logic                               hvout_valid_q;
  logic [HV_DIMENSION-1:0]            hvout_q;
  logic [HV_DIMENSION-1:0]            enc_d;
  logic [NGRAM-1:0][HV_DIMENSION-1:0] term;
  logic                               accept;
  logic                               flush_hist;

`ifdef TEMPORAL_ENCODER_FLUSH_EN
  assign flush_hist = flush;
`else
  assign flush_hist = 1'b0;
`endif

  // Single output register, no skid buffer: a new input fits only if the slot drains.
  assign hvin_ready  = !hvout_valid_q || hvout_ready;
  assign accept      = hvin_valid && hvin_ready;
  assign hvout_valid = hvout_valid_q;
  assign hvout       = hvout_q;

  assign term[0] = hvin;

  if (NGRAM > 1) begin : g_hist
    logic [HV_DIMENSION-1:0] hist_q [NGRAM-1];

    for (genvar k = 1; k < NGRAM; k++) begin : g_perm
      hv_permute #(.W(HV_DIMENSION), .K(k)) u_perm (
        .x_i (hist_q[k-1]),
        .y_o (term[k])
      );
    end

    always_ff @(posedge clk) begin
      // NOTE: the history is cleared on reset on purpose: start-up outputs are
      // defined against an all-zero history, so these registers cannot be left unreset.
      if (!rst) begin
        for (int k = 0; k < NGRAM-1; k++) hist_q[k] <= '0;
      end else if (accept) begin
        hist_q[0] <= hvin;
        for (int k = 1; k < NGRAM-1; k++) hist_q[k] <= flush_hist ? '0 : hist_q[k-1];
      end else if (flush_hist) begin
        for (int k = 0; k < NGRAM-1; k++) hist_q[k] <= '0;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves enc_d unassigned (no latch).
    enc_d = '0;
    for (int k = 0; k < NGRAM; k++) enc_d = enc_d ^ term[k];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      hvout_valid_q <= 1'b0;
      hvout_q       <= '0;
    end else if (accept) begin
      hvout_valid_q <= 1'b1;
      hvout_q       <= enc_d;
    end else if (hvout_ready) begin
      hvout_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hv_temporal_encoder.sv
// Testbench for hv_temporal_encoder: directed D=8 start-up/backpressure steps plus
// randomized D=2000 streams checked against a history-queue reference model.
module tb_hv_temporal_encoder;

  localparam int D  = 2000;
  localparam int NG = 3;
  typedef logic [D-1:0] wv_t;

  logic clk = 1'b0;
  logic rst;

  // D=8 instance
  logic       v8, r8_in, vo8, ro8;
  logic [7:0] in8, out8;
  // D=2000 instance
  logic wvin, wrdy, wvout, wordy;
  wv_t  win, wout;
`ifdef TEMPORAL_ENCODER_FLUSH_EN
  logic flush8, wflush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  wv_t hist[$];   // most recent accepted input at index 0
  wv_t exp_q[$];  // expected outputs in order

  always #5 clk = ~clk;

  hv_temporal_encoder #(.HV_DIMENSION(8), .NGRAM(NG)) dut8 (
    .clk         (clk),
    .rst         (rst),
`ifdef TEMPORAL_ENCODER_FLUSH_EN
    .flush       (flush8),
`endif
    .hvin_valid  (v8),
    .hvin_ready  (r8_in),
    .hvin        (in8),
    .hvout_valid (vo8),
    .hvout_ready (ro8),
    .hvout       (out8)
  );

  hv_temporal_encoder #(.HV_DIMENSION(D), .NGRAM(NG)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TEMPORAL_ENCODER_FLUSH_EN
    .flush       (wflush),
`endif
    .hvin_valid  (wvin),
    .hvin_ready  (wrdy),
    .hvin        (win),
    .hvout_valid (wvout),
    .hvout_ready (wordy),
    .hvout       (wout)
  );

  task automatic check(input string tag, input wv_t obs, input wv_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic wv_t rotl(input wv_t x, input int k);
    wv_t r = x;
    for (int i = 0; i < k; i++) r = {r[D-2:0], r[D-1]};
    return r;
  endfunction

  // Reference: XOR of current input with k-times rotated k-th previous input
  function automatic wv_t model_accept(input wv_t x);
    wv_t r = x;
    foreach (hist[i]) r ^= rotl(hist[i], i + 1);
    hist.push_front(x);
    if (hist.size() > NG - 1) void'(hist.pop_back());
    return r;
  endfunction

  function automatic wv_t rand_hv();
    wv_t r;
    for (int i = 0; i < D; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Drive n vectors into the wide DUT; random_gaps=0 streams at full rate.
  task automatic run_wide(input int n, input bit random_gaps, input int budget);
    int  sent = 0, received = 0, cycles = 0, gap = 0, rgap = 0;
    bit  last_acc = 0, prev_stall = 0;
    wv_t prev_out = '0;
    wvin = 1'b0;
    while (received < n && cycles < budget) begin
      @(negedge clk);
      if (sent < n) begin
        if (!wvin || last_acc) begin
          if (gap == 0) begin
            wvin = 1'b1;
            win  = rand_hv();
            gap  = random_gaps ? $urandom_range(0, 15) : 0;
          end else begin
            wvin = 1'b0;
            gap--;
          end
        end
      end else begin
        wvin = 1'b0;
      end
      if (!random_gaps) wordy = 1'b1;
      else if (rgap > 0) begin
        wordy = 1'b0;
        rgap--;
      end else begin
        wordy = 1'b1;
        if ($urandom_range(0, 3) == 0) rgap = $urandom_range(0, 15);
      end
      #1;
      if (prev_stall) begin
        check("hold_data", wout, prev_out);
        check("hold_valid", wvout, 1);
      end
      if (last_acc) check("latency_valid", wvout, 1);
      if (wvout && !wordy) check("bp_ready", wrdy, 0);
      if (wvout && wordy) begin
        if (exp_q.size() == 0) check("spurious_out", wvout, 0);
        else begin
          check("stream_data", wout, exp_q.pop_front());
          received++;
        end
      end
      last_acc = wvin && wrdy;
      if (last_acc) begin
        exp_q.push_back(model_accept(win));
        sent++;
      end
      prev_stall = wvout && !wordy;
      prev_out   = wout;
      cycles++;
    end
    check("outputs_received", received, n);
    wvin = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wv_t x;
    rst = 1'b0;
    v8 = 1'b0; in8 = '0; ro8 = 1'b0;
    wvin = 1'b0; win = '0; wordy = 1'b0;
`ifdef TEMPORAL_ENCODER_FLUSH_EN
    flush8 = 1'b0; wflush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_vo8", vo8, 0);
    check("rst_out8", out8, 0);
    check("rst_ready8", r8_in, 1);
    check("rst_wvout", wvout, 0);
    check("rst_wout", wout, '0);
    check("rst_wready", wrdy, 1);

    // Start-up on D=8: zero history for the first outputs
    rst = 1'b1;
    v8 = 1'b1; in8 = 8'b0000_0001; ro8 = 1'b1;
    @(negedge clk);
    check("out0_valid", vo8, 1);
    check("out0", out8, 8'b0000_0001);
    in8 = 8'b1000_0000;
    @(negedge clk);
    check("out1", out8, 8'b1000_0010);
    in8 = 8'b0000_0000;
    @(negedge clk);
    check("out2", out8, 8'b0000_0101);
    v8 = 1'b0;
    @(negedge clk);
    check("drain_valid", vo8, 0);
    check("drain_hold", out8, 8'b0000_0101);

    // Backpressure on D=8: in 0x10 -> 0x12, then stall with changing inputs
    ro8 = 1'b0; v8 = 1'b1; in8 = 8'h10;
    @(negedge clk);
    check("bp_first", out8, 8'h12);
    for (int i = 0; i < 10; i++) begin
      in8 = 8'($urandom);
      #1;
      check("bp8_ready", r8_in, 0);
      check("bp8_valid", vo8, 1);
      check("bp8_data", out8, 8'h12);
      @(negedge clk);
    end
    check("bp8_final", out8, 8'h12);
    in8 = 8'h21; ro8 = 1'b1;
    @(negedge clk);
    check("bp_release", out8, 8'h01);
    check("bp_release_v", vo8, 1);
    v8 = 1'b0;
    @(negedge clk);
    check("bp_drained", vo8, 0);

    // D=2000: full-rate streaming, then randomized gaps
    run_wide(40, 1'b0, 200);
    run_wide(380, 1'b1, 40000);

    // Reset mid-stream with an output pending
    run_wide(5, 1'b0, 50);
    @(negedge clk);
    wvin = 1'b1; win = rand_hv(); wordy = 1'b0;
    @(negedge clk);
    #1;
    check("pending_valid", wvout, 1);
    rst = 1'b0; wvin = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_valid", wvout, 0);
    check("midrst_data", wout, '0);
    hist.delete();
    exp_q.delete();
    rst = 1'b1;
    x = rand_hv();
    wvin = 1'b1; win = x; wordy = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_valid", wvout, 1);
    check("post_rst_data", wout, x);
    void'(model_accept(x));
    wvin = 1'b0;
    run_wide(6, 1'b0, 60);

`ifdef TEMPORAL_ENCODER_FLUSH_EN
    @(negedge clk);
    wflush = 1'b1;
    @(negedge clk);
    wflush = 1'b0;
    hist.delete();
    x = rand_hv();
    wvin = 1'b1; win = x; wordy = 1'b1;
    @(negedge clk);
    #1;
    check("flush_data", wout, x);
    void'(model_accept(x));
    wvin = 1'b0;
    run_wide(4, 1'b0, 40);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
